// File: rtl/out_port_tx_if.sv
// CPU-side write port and serial/status signals of the output-port transmitter.
interface out_port_tx_if #(
  parameter int unsigned AW = 2
);
  logic          doOut;
  logic [7:0]    dbus;
  logic          tx;
  logic          busy;
  logic          full;
  logic          overflow;
  logic [AW:0]   count;

  // CPU / bench side: drives the write strobe and data, observes status
  modport master (
    output doOut, dbus,
    input  tx, busy, full, overflow, count
  );

  // Transmitter side
  modport slave (
    input  doOut, dbus,
    output tx, busy, full, overflow, count
  );
endinterface

// File: rtl/out_port_tx.sv
// Output-port serial transmitter: buffers CPU output writes in a small FIFO
// and sends each byte as UART 8N1, with back-to-back frames when queued.
module out_port_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AW           = 2
) (
  input  logic          clk,
  input  logic          reset,
  out_port_tx_if.slave  bus
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            tx_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     cnt;
  logic            ovf;
  logic            baud_done;
  logic            pop;
  logic            push;

  // Pop when idle or at the last cycle of STOP; a push may reuse the popped slot
  always_comb begin
    baud_done = (baud == BAUD_LAST);
    pop       = (cnt != '0) && ((state == IDLE) || ((state == STOP) && baud_done));
    push      = bus.doOut && ((cnt < DEPTH_C) || pop);
  end

  // FIFO storage; no reset needed since occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.dbus;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
      if (bus.doOut && !push) ovf <= 1'b1;
    end
  end

  // Frame sequencer: START, 8 data bits LSB first, STOP; tx registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else if (pop) begin
      shift   <= mem[rd_ptr];
      state   <= START;
      baud    <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (baud_done) begin
            state   <= DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx_q    <= shift[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'(7)) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'(1);
              tx_q    <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            state <= IDLE;
            baud  <= '0;
            tx_q  <= 1'b1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE) || (cnt != '0);
  assign bus.full     = (cnt == DEPTH_C);
  assign bus.overflow = ovf;
  assign bus.count    = cnt;

endmodule

// File: tb/tb_out_port_tx.sv
// Directed bench for out_port_tx: a serial monitor decodes frames off tx and
// checks them against a scoreboard of bytes queued when writes are driven.
module tb_out_port_tx;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic clk = 1'b0;
  logic reset;

  out_port_tx_if #(.AW(AW)) bus ();

  out_port_tx #(.CLKS_PER_BIT(CPB), .DEPTH(4), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial monitor: frame starts on tx low, each bit held CPB cycles
  int         mcyc = 0;
  bit         inframe = 0;
  logic [9:0] fbits;
  logic       cur;
  always @(negedge clk) begin
    if (reset) inframe = 0;
    else if (!inframe) begin
      if (bus.tx === 1'b0) begin
        inframe = 1;
        mcyc    = 0;
      end
    end else mcyc++;
    if (!reset && inframe) begin
      if (mcyc % CPB == 0) begin
        cur               = bus.tx;
        fbits[mcyc / CPB] = bus.tx;
      end else begin
        check("bit_stable", 32'(bus.tx), 32'(cur));
      end
      if (mcyc == 10 * CPB - 1) begin
        inframe = 0;
        check("stop_bit", 32'(fbits[9]), 1);
        check("frame_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check("frame_data", 32'(fbits[8:1]), 32'(sb.pop_front()));
      end
    end
  end

  // Busy-cycle counter from the first low tx, and peak FIFO occupancy
  int busy_cyc = 0;
  int peak     = 0;
  bit seen_low = 0;
  always @(negedge clk) begin
    if (reset || bus.busy !== 1'b1) seen_low = 0;
    else begin
      if (bus.tx === 1'b0) seen_low = 1;
      if (seen_low) busy_cyc++;
    end
    if (!reset && int'(bus.count) > peak) peak = int'(bus.count);
  end

  task automatic wait_drain(input string tag, input int exp_cyc);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(n < 2000), 1);
    check({tag, "_cycles"}, 32'(busy_cyc), 32'(exp_cyc));
    check({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    #1000000;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    bus.doOut = 1'b0;
    bus.dbus  = 8'h00;
    #1;
    check("rst_tx", 32'(bus.tx), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single byte 0xA5
    @(negedge clk);
    busy_cyc = 0;
    bus.doOut = 1'b1; bus.dbus = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    bus.doOut = 1'b0;
    check("t1_count1", 32'(bus.count), 1);
    check("t1_tx_pre", 32'(bus.tx), 1);
    check("t1_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("t1_tx_start", 32'(bus.tx), 0);
    check("t1_count0", 32'(bus.count), 0);
    wait_drain("t1", 40);
    check("t1_ovf", 32'(bus.overflow), 0);

    // Three back-to-back bytes
    @(negedge clk);
    busy_cyc = 0; peak = 0;
    bus.doOut = 1'b1; bus.dbus = 8'h01; sb.push_back(8'h01);
    @(negedge clk);
    bus.dbus = 8'h02; sb.push_back(8'h02);
    @(negedge clk);
    bus.dbus = 8'h03; sb.push_back(8'h03);
    @(negedge clk);
    bus.doOut = 1'b0;
    wait_drain("t2", 120);
    check("t2_peak", 32'(peak), 2);

    // Six writes from idle: the sixth overflows
    @(negedge clk);
    busy_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.doOut = 1'b1;
      bus.dbus  = 8'(8'h10 + i);
      if (i < 5) sb.push_back(8'(8'h10 + i));
      @(negedge clk);
      if (i == 4) begin
        check("t3_full_early", 32'(bus.full), 1);
        check("t3_ovf_early", 32'(bus.overflow), 0);
      end
    end
    bus.doOut = 1'b0;
    check("t3_count", 32'(bus.count), 4);
    check("t3_full", 32'(bus.full), 1);
    check("t3_ovf", 32'(bus.overflow), 1);
    wait_drain("t3", 200);
    check("t3_ovf_sticky", 32'(bus.overflow), 1);

    // Clear overflow
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t3_ovf_cleared", 32'(bus.overflow), 0);

    // Full FIFO, write lands on the STOP-end pop edge
    @(negedge clk);
    busy_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.doOut = 1'b1;
      bus.dbus  = 8'(8'h20 + i);
      sb.push_back(8'(8'h20 + i));
      @(negedge clk);
    end
    bus.doOut = 1'b0;
    check("t4_count_full", 32'(bus.count), 4);
    check("t4_ovf0", 32'(bus.overflow), 0);
    repeat (36) @(negedge clk);
    check("t4_count_prepop", 32'(bus.count), 4);
    bus.doOut = 1'b1; bus.dbus = 8'h25; sb.push_back(8'h25);
    @(negedge clk);
    bus.doOut = 1'b0;
    check("t4_count_after", 32'(bus.count), 4);
    check("t4_ovf_after", 32'(bus.overflow), 0);
    wait_drain("t4", 240);

    // Reset mid-frame with two bytes queued
    @(negedge clk);
    bus.doOut = 1'b1; bus.dbus = 8'hFF; sb.push_back(8'hFF);
    @(negedge clk);
    bus.dbus = 8'hAA; sb.push_back(8'hAA);
    @(negedge clk);
    bus.dbus = 8'h55; sb.push_back(8'h55);
    @(negedge clk);
    bus.doOut = 1'b0;
    check("t5_count_q", 32'(bus.count), 2);
    repeat (18) @(negedge clk);
    check("t5_busy_mid", 32'(bus.busy), 1);
    reset = 1'b1;
    sb.delete();
    #1;
    check("t5_tx", 32'(bus.tx), 1);
    check("t5_count", 32'(bus.count), 0);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_full", 32'(bus.full), 0);
    check("t5_ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    // dbus toggling with doOut low has no effect
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t6_tx", 32'(bus.tx), 1);
      check("t6_count", 32'(bus.count), 0);
      check("t6_busy", 32'(bus.busy), 0);
      bus.dbus = 8'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_port_tx.md
Name: out_port_tx

Overview:
- Serial transmitter for the CPU output port.
- Latches each byte the CPU writes with `doOut` from `dbus` into a small FIFO, then sends it as UART 8N1 on `tx`.
- Sits beside the register file on the same `dbus`/`doOut` write path and gives the design an off-chip serial link instead of only a parallel `qreg` value.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal values are 2 or more.
- DEPTH, 4, FIFO entries; must be a power of 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- doOut  input  1  output-write strobe from the control bits; sampled on the rising edge of clk.
- dbus  input  8  data bus; sampled with doOut.
- tx  output  1  serial line; idles high.
- busy  output  1  high when the transmitter is not IDLE or the FIFO is not empty.
- full  output  1  high when the FIFO count equals DEPTH.
- overflow  output  1  sticky flag; a write was dropped.
- count  output  AW+1  current FIFO occupancy, 0 to DEPTH.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, tx=1, FIFO empty (rd_ptr=wr_ptr=0, count=0).
  - bit counter=0, baud counter=0, shift register=0, overflow=0.
  - Outputs while reset is held: busy=0, full=0.
  - Reset mid-frame aborts the frame immediately: tx goes to 1 asynchronously and FIFO contents are discarded.
- Write:
  - On a rising edge with doOut=1, dbus is pushed at wr_ptr, provided count<DEPTH or a pop happens on the same edge.
  - Otherwise the byte is dropped and overflow is set; it stays set until reset.
- Pop:
  - Happens on any edge where state is IDLE and count>0.
  - Also happens on the final cycle of STOP when count>0, for back-to-back frames.
  - The popped byte loads the shift register; state moves to START and the baud counter resets to 0.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- State machine (the baud counter counts 0..CLKS_PER_BIT-1 within each bit):
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right by 1 and increment the bit index. After bit index 7 completes, go to STOP. Data goes out LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then go to START via pop if count>0, else IDLE.
- tx is a registered output (no glitches).
- Latency from an empty, idle block:
  - Write on edge N: count=1 after edge N.
  - Pop on edge N+1: tx falls after edge N+1 and count returns to 0.
- Frame length: exactly 10*CLKS_PER_BIT cycles. There is no idle gap between queued frames.
- busy falls on the edge where STOP ends with the FIFO empty.
- dbus is ignored when doOut=0.

Test Plan:
- Reset, then write 0xA5 once (CLKS_PER_BIT=4). Required: tx=1 before the frame; then tx=0 for 4 cycles; then bits 1,0,1,0,0,1,0,1, each 4 cycles; then 1 for 4 cycles; busy=0 after 40 cycles; overflow=0.
- Write 0x01, 0x02, 0x03 on consecutive edges. Required: count peaks at 2 (the first byte pops immediately); three frames go out back-to-back with no idle cycles, total 120 cycles; then busy=0.
- Write 6 bytes 0x10..0x15 on consecutive edges while the transmitter is idle. Required: 0x10 pops immediately; 0x11..0x14 fill the FIFO (full=1, count=4); 0x15 is dropped and overflow=1. The serial output is 0x10..0x14 only.
- FIFO full and a write lands on the STOP-end pop edge. Required: the write is accepted, count stays 4, overflow does not change, and that byte is transmitted in order later.
- Assert reset halfway through the DATA bits of 0xFF with 2 bytes queued. Required: tx=1 immediately; count=0, busy=0, overflow=0; no further frames after reset is released.
- Hold doOut=0 while dbus toggles randomly for 100 cycles. Required: tx stays 1, count stays 0, busy stays 0.
